// File: rtl/audio_dac_serializer_if.sv
// audio_dac_serializer_if
// Parallel sample push interface between the filter datapath (master) and the
// DAC serializer (slave).
//   write           : push request for one stereo pair
//   writedata_left  : left sample, two's complement
//   writedata_right : right sample, two's complement
//   write_ready     : serializer FIFO not full (registered); a push happens
//                     only when write && write_ready
interface audio_dac_serializer_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata_left;
    logic [DATA_WIDTH-1:0] writedata_right;
    logic                  write_ready;

    modport master (
        output write,
        output writedata_left,
        output writedata_right,
        input  write_ready
    );

    modport slave (
        input  write,
        input  writedata_left,
        input  writedata_right,
        output write_ready
    );
endinterface

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer
// Buffers stereo sample pairs in a small FIFO and shifts them out MSB-first,
// left-justified, on AUD_DACDAT, framed by the CODEC-mastered AUD_BCLK and
// AUD_DACLRCK (high = left channel).
//   CLOCK_50    : sole clock, rising edge
//   reset       : asynchronous, active-high
//   bus         : sample push interface (slave side)
//   AUD_BCLK    : CODEC bit clock, asynchronous
//   AUD_DACLRCK : CODEC frame clock, asynchronous
//   AUD_DACDAT  : serial data to CODEC
//   fifo_count  : pairs currently buffered
//   underflow   : sticky, a frame started with the FIFO empty
// Build option DAC_HOLD_LAST_EN: on underflow re-send the last popped pair
// instead of zeros.
module audio_dac_serializer #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    audio_dac_serializer_if.slave       bus,
    input  logic                        AUD_BCLK,
    input  logic                        AUD_DACLRCK,
    output logic                        AUD_DACDAT,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        underflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {WAIT_FRAME, LEFT, RIGHT} state_t;

    // ---------------------------------------------------------------- pin sync
    // [0],[1] form the synchronizer, [2] holds the previous synchronized level.
    logic [2:0] bclk_sync, lr_sync;
    logic       bclk_fall, lr_rise, lr_fall;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; the shift chains below rely on that.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            bclk_fall <= 1'b0;
            lr_rise   <= 1'b0;
            lr_fall   <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], AUD_BCLK};
            lr_sync   <= {lr_sync[1:0], AUD_DACLRCK};
            bclk_fall <= bclk_sync[2] & ~bclk_sync[1];
            lr_rise   <= lr_sync[1] & ~lr_sync[2];
            lr_fall   <= lr_sync[2] & ~lr_sync[1];
        end
    end

    // -------------------------------------------------------------------- FIFO
    logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count, count_next;
    logic                    write_ready_q;
    logic                    push, pop, fifo_empty;
    logic [DATA_WIDTH-1:0]   head_left, head_right;

    assign fifo_empty     = (count == '0);
    // write_ready_q is the registered not-full flag, so a push into a full
    // FIFO is rejected even when a pop happens in the same cycle.
    assign push           = bus.write && write_ready_q;
    // No bypass: a pop only ever sees pairs pushed in earlier cycles.
    assign pop            = lr_rise && !fifo_empty;
    assign {head_left, head_right} = mem[rd_ptr];
    assign bus.write_ready = write_ready_q;
    assign fifo_count      = count;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    // NOTE: the sample storage has no reset; only slots between the pointers
    // are ever read, so stale contents are harmless.
    always_ff @(posedge CLOCK_50) begin
        if (push)
            mem[wr_ptr] <= {bus.writedata_left, bus.writedata_right};
    end

    // Pointers wrap on their own because the depth is a power of two.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            write_ready_q <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count         <= count_next;
            write_ready_q <= (count_next != CW'(FIFO_DEPTH));
        end
    end

    // ------------------------------------------------------------- serializer
    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [DATA_WIDTH-1:0] hold_left, hold_right, hold_left_next, hold_right_next;
    logic                  underflow_next;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= WAIT_FRAME;
            shift_reg  <= '0;
            hold_left  <= '0;
            hold_right <= '0;
            underflow  <= 1'b0;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            hold_left  <= hold_left_next;
            hold_right <= hold_right_next;
            underflow  <= underflow_next;
        end
    end

    // NOTE: every output of this block is defaulted first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next      = state;
        shift_next      = shift_reg;
        hold_left_next  = hold_left;
        hold_right_next = hold_right;
        underflow_next  = underflow;

        if (lr_rise) begin
            // Frame start is the only pop point; an LR edge mid-word simply
            // truncates whatever is still in the shift register.
            state_next = LEFT;
            if (pop) begin
                hold_left_next  = head_left;
                hold_right_next = head_right;
            end else begin
                underflow_next = 1'b1;
`ifdef DAC_HOLD_LAST_EN
                hold_left_next  = hold_left;
                hold_right_next = hold_right;
`else
                hold_left_next  = '0;
                hold_right_next = '0;
`endif
            end
            shift_next = hold_left_next;
        end else if (state != WAIT_FRAME) begin
            if (lr_fall) begin
                state_next = RIGHT;
                shift_next = hold_right;
            end else if (bclk_fall) begin
                // Zero fill makes the line idle low once the word is out.
                shift_next = {shift_reg[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    // The shift register is all-zero in WAIT_FRAME, so the line stays low there.
    assign AUD_DACDAT = shift_reg[DATA_WIDTH-1];

endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb_audio_dac_serializer
// Drives randomized sample pairs and CODEC clock patterns into
// audio_dac_serializer and checks every cycle against a behavioural model
// (queue of pairs, bit index into the current word, pin history delayed by
// the synchronizer latency). Honours DAC_HOLD_LAST_EN like the design.
module tb_audio_dac_serializer;
    localparam int W = 24;
    localparam int D = 4;

    logic               clk  = 1'b0;
    logic               rst  = 1'b1;
    logic               bclk = 1'b1;
    logic               lrck = 1'b0;
    logic               dacdat;
    logic               underflow;
    logic [$clog2(D):0] fifo_count;

    int tests_run    = 0;
    int tests_failed = 0;

    audio_dac_serializer_if #(.DATA_WIDTH(W)) bus ();

    audio_dac_serializer #(.DATA_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .CLOCK_50    (clk),
        .reset       (rst),
        .bus         (bus),
        .AUD_BCLK    (bclk),
        .AUD_DACLRCK (lrck),
        .AUD_DACDAT  (dacdat),
        .fifo_count  (fifo_count),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    logic [2*W-1:0] q[$];
    int             m_state;     // 0 idle, 1 left, 2 right
    int             m_idx;       // bits already shifted past in current word
    logic [W-1:0]   m_word, m_hold_l, m_hold_r;
    bit             m_under;
    logic [4:1]     h_lr, h_bclk; // [k] = pin level sampled k edges ago
    bit             compare_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_state = 0; m_idx = 0; m_word = '0;
            m_hold_l = '0; m_hold_r = '0; m_under = 1'b0;
            h_lr = '0; h_bclk = '0;
        end else begin
            bit rise, fall, bfall, accept;
            // Pin edge reaches the serializer three samples later.
            rise   = h_lr[3] && !h_lr[4];
            fall   = !h_lr[3] && h_lr[4];
            bfall  = !h_bclk[3] && h_bclk[4];
            accept = bus.write && (q.size() < D);
            if (rise) begin
                if (q.size() == 0) begin
                    m_under = 1'b1;
`ifndef DAC_HOLD_LAST_EN
                    m_hold_l = '0;
                    m_hold_r = '0;
`endif
                end else begin
                    {m_hold_l, m_hold_r} = q.pop_front();
                end
                m_state = 1; m_word = m_hold_l; m_idx = 0;
            end else if (fall && m_state != 0) begin
                m_state = 2; m_word = m_hold_r; m_idx = 0;
            end else if (bfall && m_state != 0 && m_idx < W) begin
                m_idx++;
            end
            if (accept)
                q.push_back({bus.writedata_left, bus.writedata_right});
            h_lr   = {h_lr[3:1], lrck};
            h_bclk = {h_bclk[3:1], bclk};
        end
    end

    function automatic logic exp_dac();
        if (m_state == 0 || m_idx >= W)
            return 1'b0;
        return m_word[W-1-m_idx];
    endfunction

    always @(negedge clk) begin
        if (compare_en) begin
            if (rst) begin
                check("rst_dacdat", dacdat, 0);
                check("rst_fifo_count", fifo_count, 0);
                check("rst_write_ready", bus.write_ready, 1);
                check("rst_underflow", underflow, 0);
            end else begin
                check("dacdat", dacdat, exp_dac());
                check("fifo_count", fifo_count, q.size());
                check("write_ready", bus.write_ready, q.size() < D);
                check("underflow", underflow, m_under);
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] l, input logic [W-1:0] r);
        bus.write = 1'b1; bus.writedata_left = l; bus.writedata_right = r;
        wait_cycles(1);
        bus.write = 1'b0;
    endtask

    // LR edges coincide with a BCLK falling edge, as a CODEC produces them.
    task automatic lr_edge(input logic v);
        bclk = 1'b0;
        lrck = v;
    endtask

    // Called 5 cycles after the LR edge; captures the first W presented bits.
    task automatic half_rest(input int nfalls, output logic [W-1:0] cap);
        cap = '0;
        cap[W-1] = dacdat;
        for (int k = 1; k <= nfalls; k++) begin
            bclk = 1'b1; wait_cycles(5);
            bclk = 1'b0; wait_cycles(5);
            if (k < W) cap[W-1-k] = dacdat;
        end
        bclk = 1'b1; wait_cycles(5);
    endtask

    task automatic half_frame(input logic v, input int nfalls, output logic [W-1:0] cap);
        lr_edge(v);
        wait_cycles(5);
        half_rest(nfalls, cap);
    endtask

    initial begin
        logic [W-1:0] cl, cr, exp_l, exp_r, last_l, last_r;
        logic [W-1:0] pl[4], pr[4];

        bus.write = 1'b0; bus.writedata_left = '0; bus.writedata_right = '0;
        wait_cycles(1);
        compare_en = 1'b1;
        wait_cycles(3);
        check("reset_dacdat", dacdat, 0);
        check("reset_write_ready", bus.write_ready, 1);
        check("reset_fifo_count", fifo_count, 0);
        check("reset_underflow", underflow, 0);
        rst = 1'b0;
        wait_cycles(5);

        // Basic frame with known words.
        push(24'hA5F00F, 24'h123456);
        check("t1_count_after_push", fifo_count, 1);
        half_frame(1'b1, 24, cl);
        check("t1_count_after_pop", fifo_count, 0);
        check("t1_left_word", cl, 24'hA5F00F);
        check("t1_left_pad", dacdat, 0);
        half_frame(1'b0, 24, cr);
        check("t1_right_word", cr, 24'h123456);
        check("t1_underflow", underflow, 0);

        // Fill the FIFO, push once more while full, then drain.
        for (int i = 0; i < 4; i++) begin
            pl[i] = W'($urandom); pr[i] = W'($urandom);
            push(pl[i], pr[i]);
        end
        check("t2_ready_full", bus.write_ready, 0);
        push(W'($urandom), W'($urandom));
        check("t2_count_full", fifo_count, 4);
        for (int i = 0; i < 4; i++) begin
            half_frame(1'b1, 24, cl);
            if (i == 0) check("t2_ready_after_pop", bus.write_ready, 1);
            check("t2_left", cl, pl[i]);
            half_frame(1'b0, 24, cr);
            check("t2_right", cr, pr[i]);
        end
        last_l = pl[3]; last_r = pr[3];

        // Frame with the FIFO empty.
`ifdef DAC_HOLD_LAST_EN
        exp_l = last_l; exp_r = last_r;
`else
        exp_l = '0; exp_r = '0;
`endif
        half_frame(1'b1, 24, cl);
        check("t3_underflow", underflow, 1);
        check("t3_left", cl, exp_l);
        half_frame(1'b0, 24, cr);
        check("t3_right", cr, exp_r);

        // Push in the same cycle the frame start reaches the serializer.
        pl[0] = W'($urandom); pr[0] = W'($urandom);
        lr_edge(1'b1);
        wait_cycles(3);
        push(pl[0], pr[0]);
        wait_cycles(1);
        half_rest(24, cl);
        check("t4_left_underflow", cl, exp_l);
        check("t4_count", fifo_count, 1);
        half_frame(1'b0, 24, cr);
        check("t4_right_underflow", cr, exp_r);
        half_frame(1'b1, 24, cl);
        check("t4_left_next", cl, pl[0]);
        half_frame(1'b0, 24, cr);
        check("t4_right_next", cr, pr[0]);

        // Reset in the middle of a left word.
        push(24'hFFFFFF, W'($urandom));
        push(W'($urandom), W'($urandom));
        half_frame(1'b1, 10, cl);
        check("t5_pre_reset_dacdat", dacdat, 1);
        rst = 1'b1;
        wait_cycles(1);
        check("t5_dacdat", dacdat, 0);
        check("t5_count", fifo_count, 0);
        check("t5_underflow_cleared", underflow, 0);
        lrck = 1'b0;
        wait_cycles(5);
        rst = 1'b0;
        wait_cycles(2);
        half_frame(1'b0, 5, cl);
        check("t5_quiet", cl, 0);
        pl[1] = W'($urandom); pr[1] = W'($urandom);
        push(pl[1], pr[1]);
        half_frame(1'b1, 24, cl);
        check("t5_resume_left", cl, pl[1]);
        half_frame(1'b0, 24, cr);
        check("t5_resume_right", cr, pr[1]);

        // LR toggles after only 16 bit clocks.
        push(24'hFFFF80, 24'h400001);
        half_frame(1'b1, 16, cl);
        check("t6_left_trunc", cl, 24'hFFFF80);
        lr_edge(1'b0);
        wait_cycles(3);
        check("t6_before_switch", dacdat, 1);
        wait_cycles(1);
        check("t6_right_msb", dacdat, 0);
        wait_cycles(1);
        half_rest(24, cr);
        check("t6_right_word", cr, 24'h400001);

        wait_cycles(4);
        compare_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
